aes_iter_core: RTL and testbench

AES_ITER_CORE -- requirements
Module: aes_iter_core

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_round_comb.sv | 44 ++++
 rtl/aes_iter_core.sv | 143 ++++++++++++++
 tb/tb_aes_iter_core.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative encryption core.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef logic [3:0] round_t;

    // Number of rounds for a given key length (only 128 and 256 are legal)
    function automatic int nr_of(input int key_len);
        return (key_len == 256) ? 14 : 10;
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product by shift-and-add
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254, which maps 0 to 0) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] y;
        inv = 8'h01;
        y   = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gf_mul(inv, y);
            y = gf_mul(y, y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for schedule iteration idx (1-based): repeated doubling of 0x01
    function automatic logic [7:0] rcon(input round_t idx);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 2; i <= 10; i++) begin
            if (round_t'(i) <= idx) r = xtime(r);
        end
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         mix_en_i,
    output logic [127:0] state_o
);

    logic [127:0] sr;

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // SubBytes then ShiftRows: byte (row r, column c) comes from column (c + r) mod 4
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 8*(r + 4*c) -: 8] = sbox(state_i[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
    end

    // MixColumns per column (bypassed in the final round), then add the round key
    always_comb begin
        state_o = '0;
        for (int c = 0; c < 4; c++) begin
            if (mix_en_i) begin
                state_o[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]) ^ rk_i[127 - 32*c -: 32];
            end else begin
                state_o[127 - 32*c -: 32] = sr[127 - 32*c -: 32] ^ rk_i[127 - 32*c -: 32];
            end
        end
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one round per clock, round keys expanded on the fly.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_LEN = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       plaintext,
    input  logic [KEY_LEN-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       ciphertext,
    output logic               busy
);

    localparam int     NR   = nr_of(KEY_LEN);
    localparam round_t NR_R = round_t'(NR);

    state_e             st_q, st_d;
    round_t             round_q, round_d;
    logic [127:0]       state_q, state_d;
    logic [KEY_LEN-1:0] sched_q, sched_d;
    logic [127:0]       ct_q, ct_d;
    logic               rdy_q;

    logic [127:0]       rk_cur;
    logic [KEY_LEN-1:0] sched_nxt;
    logic [127:0]       round_out;
    logic               last_round;
    logic               mix_en;

    // Key schedule step: sched_q holds the words preceding the current round key
    if (KEY_LEN == 128) begin : g_ks128
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        assign {w0, w1, w2, w3} = sched_q;
        assign t  = sub_word(rot_word(w3)) ^ {rcon(round_q), 24'h0};
        assign n0 = w0 ^ t;
        assign n1 = w1 ^ n0;
        assign n2 = w2 ^ n1;
        assign n3 = w3 ^ n2;
        assign rk_cur    = {n0, n1, n2, n3};
        assign sched_nxt = {n0, n1, n2, n3};
    end else if (KEY_LEN == 256) begin : g_ks256
        // Window of 8 words w[4(r-1)] .. w[4r+3]; round key r is its upper half (low bits)
        logic [31:0] w0, w1, w2, w3, w7, t, n0, n1, n2, n3;
        round_t      rc_idx;
        assign w0 = sched_q[255:224];
        assign w1 = sched_q[223:192];
        assign w2 = sched_q[191:160];
        assign w3 = sched_q[159:128];
        assign w7 = sched_q[31:0];
        // Odd rounds produce word i with i mod 8 == 0, even rounds i mod 8 == 4
        assign rc_idx = round_t'((round_q + 4'd1) >> 1);
        assign t  = round_q[0] ? (sub_word(rot_word(w7)) ^ {rcon(rc_idx), 24'h0})
                               : sub_word(w7);
        assign n0 = w0 ^ t;
        assign n1 = w1 ^ n0;
        assign n2 = w2 ^ n1;
        assign n3 = w3 ^ n2;
        assign rk_cur    = sched_q[127:0];
        assign sched_nxt = {sched_q[127:0], n0, n1, n2, n3};
    end else begin : g_bad_key_len
        $error("aes_iter_core: KEY_LEN must be 128 or 256");
    end

    assign last_round = (round_q == NR_R);
    assign mix_en     = !last_round;

    aes_round_comb u_round (
        .state_i  (state_q),
        .rk_i     (rk_cur),
        .mix_en_i (mix_en),
        .state_o  (round_out)
    );

    // Control registers: FSM state, round counter, and the post-reset ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            round_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            round_q <= round_d;
            rdy_q   <= 1'b1;
        end
    end

    // Datapath registers: cipher state, key schedule window, ciphertext
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            sched_q <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            sched_q <= sched_d;
            ct_q    <= ct_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate rounds, hold result in DONE
    always_comb begin
        st_d    = st_q;
        round_d = round_q;
        state_d = state_q;
        sched_d = sched_q;
        ct_d    = ct_q;
        unique case (st_q)
            ST_IDLE: begin
                if (in_valid && rdy_q) begin
                    state_d = plaintext ^ key[KEY_LEN-1 -: 128];
                    sched_d = key;
                    round_d = round_t'(1);
                    st_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = round_out;
                sched_d = sched_nxt;
                if (last_round) begin
                    ct_d = round_out;
                    st_d = ST_DONE;
                end else begin
                    round_d = round_t'(round_q + 4'd1);
                end
            end
            ST_DONE: begin
                if (out_ready) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign in_ready   = (st_q == ST_IDLE) && rdy_q;
    assign busy       = (st_q != ST_IDLE);
    assign out_valid  = (st_q == ST_DONE);
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_iter_core.sv
module tb_aes_iter_core;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int ksel  = 0;

    logic         rst_n = 1'b0;
    logic         iv    = 1'b0;
    logic         ordy  = 1'b0;
    logic [127:0] pt    = '0;
    logic [255:0] kin   = '0;

    logic iv0, iv1, or0, or1;
    logic ir0, ov0, bz0, ir1, ov1, bz1;
    logic [127:0] ct0, ct1;
    logic ir, ov, bz;
    logic [127:0] ct;

    assign iv0 = iv && (ksel == 0);
    assign iv1 = iv && (ksel == 1);
    assign or0 = ordy && (ksel == 0);
    assign or1 = ordy && (ksel == 1);
    assign ir  = (ksel == 0) ? ir0 : ir1;
    assign ov  = (ksel == 0) ? ov0 : ov1;
    assign bz  = (ksel == 0) ? bz0 : bz1;
    assign ct  = (ksel == 0) ? ct0 : ct1;

    aes_iter_core #(.KEY_LEN(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .plaintext(pt),
        .key(kin[255:128]), .out_valid(ov0), .out_ready(or0), .ciphertext(ct0), .busy(bz0)
    );

    aes_iter_core #(.KEY_LEN(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .plaintext(pt),
        .key(kin), .out_valid(ov1), .out_ready(or1), .ciphertext(ct1), .busy(bz1)
    );

    // ---------------- reference model (FIPS-197, table driven) ----------------
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROWS[x[7:4]];
        return row[127 - 8*int'(x[3:0]) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] p, input logic [255:0] k, input int klen);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        int nk, nr;
        nk = klen / 32;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic int klen_of(input int k);
        return (k == 0) ? 128 : 256;
    endfunction

    function automatic int nr_k(input int k);
        return (k == 0) ? 10 : 14;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic accept_block(input logic [127:0] p, input logic [255:0] k, output int acc, output bit ok);
        pt = p; kin = k; iv = 1'b1; ok = 1'b0; acc = 0;
        for (int i = 0; i < 50; i++) begin
            if (ir === 1'b1) begin
                @(negedge clk);
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        iv = 1'b0;
    endtask

    task automatic wait_out(output int seen, output bit ok);
        ok = 1'b0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ov === 1'b1) begin
                seen = cyc;
                ok   = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; iv = 1'b0; ordy = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            ksel = k; #1;
            n_cmp++;
            if (ir !== 1'b0 || ov !== 1'b0 || bz !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ctrl k=%0d: in_ready/out_valid/busy=%b%b%b, required 000", k, ir, ov, bz);
            end
            n_cmp++;
            if (ct !== 128'h0) begin
                n_err++;
                $display("FAIL reset_ct k=%0d: got %h, required 0", k, ct);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; #1;
        n_cmp++;
        if (ir0 !== 1'b0 || ir1 !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: in_ready=%b%b, required 00", ir0, ir1);
        end
        @(negedge clk);
        n_cmp++;
        if (ir0 !== 1'b1 || ir1 !== 1'b1 || bz0 !== 1'b0 || bz1 !== 1'b0) begin
            n_err++;
            $display("FAIL ready_after_edge: in_ready=%b%b busy=%b%b, required 11/00", ir0, ir1, bz0, bz1);
        end
    endtask

    task automatic test_fips(input int k);
        logic [127:0] expv;
        int acc, seen;
        bit ok;
        ksel = k; ordy = 1'b0;
        if (k == 0) begin
            kin  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
            expv = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        end else begin
            kin  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
            expv = 128'h8ea2b7ca516745bfeafc49904b496089;
        end
        accept_block(128'h00112233445566778899aabbccddeeff, kin, acc, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL fips_accept k=%0d: in_ready never high within 50 cycles", k);
        end
        wait_out(seen, ok);
        n_cmp++;
        if (!ok || (seen - acc) != nr_k(k)) begin
            n_err++;
            $display("FAIL fips_latency k=%0d: got %0d cycles (seen=%0b), required %0d", k, seen - acc, ok, nr_k(k));
        end
        n_cmp++;
        if (ct !== expv) begin
            n_err++;
            $display("FAIL fips_ct k=%0d: got %h, required %h", k, ct, expv);
        end
        n_cmp++;
        if (ct !== aes_model(pt, kin, klen_of(k))) begin
            n_err++;
            $display("FAIL fips_model k=%0d: got %h, required %h", k, ct, aes_model(pt, kin, klen_of(k)));
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        n_cmp++;
        if (ov !== 1'b0 || ir !== 1'b1 || bz !== 1'b0) begin
            n_err++;
            $display("FAIL fips_handshake k=%0d: out_valid/in_ready/busy=%b%b%b, required 010", k, ov, ir, bz);
        end
    endtask

    task automatic test_hold();
        logic [127:0] p, expv;
        logic [255:0] k;
        int acc, seen;
        bit ok;
        ksel = 0; ordy = 1'b0;
        p = rnd128(); k = rnd256();
        expv = aes_model(p, k, 128);
        accept_block(p, k, acc, ok);
        wait_out(seen, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL hold_wait: out_valid not seen within 40 cycles");
        end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (ov !== 1'b1 || ir !== 1'b0 || ct !== expv) begin
                n_err++;
                $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b ct=%h, required 1/0/%h", i, ov, ir, ct, expv);
            end
            @(negedge clk);
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        n_cmp++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b, required 1/0", ir, ov);
        end
        n_cmp++;
        if (ct !== expv) begin
            n_err++;
            $display("FAIL hold_ct_kept: got %h, required %h", ct, expv);
        end
    endtask

    task automatic test_ignore_busy();
        logic [127:0] pa, expv;
        logic [255:0] ka;
        int acc, seen;
        bit ok;
        ksel = 1; ordy = 1'b0;
        pa = rnd128(); ka = rnd256();
        expv = aes_model(pa, ka, 256);
        accept_block(pa, ka, acc, ok);
        ok = 1'b0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ov === 1'b1) begin
                seen = cyc;
                ok   = 1'b1;
                break;
            end
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            pt   = rnd128();
            kin  = rnd256();
            @(negedge clk);
        end
        iv = 1'b0; ordy = 1'b0;
        n_cmp++;
        if (!ok || (seen - acc) != 14) begin
            n_err++;
            $display("FAIL ignore_latency: got %0d cycles (seen=%0b), required 14", seen - acc, ok);
        end
        n_cmp++;
        if (ct !== expv) begin
            n_err++;
            $display("FAIL ignore_ct: got %h, required %h", ct, expv);
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc, seen;
        bit ok, rose;
        ksel = 0; ordy = 1'b1;
        accept_block(rnd128(), rnd256(), acc, ok);
        repeat (4) @(negedge clk);
        rst_n = 1'b0; #1;
        n_cmp++;
        if (ov0 !== 1'b0 || bz0 !== 1'b0 || ir0 !== 1'b0 || ct0 !== 128'h0) begin
            n_err++;
            $display("FAIL midreset_async: out_valid=%b busy=%b in_ready=%b ct=%h, required 0/0/0/0", ov0, bz0, ir0, ct0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ov0 === 1'b1) rose = 1'b1;
        end
        n_cmp++;
        if (rose !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_output: out_valid rose=%b, required 0", rose);
        end
        ordy = 1'b0;
        test_fips(0);
    endtask

    task automatic test_back_to_back(input int k);
        logic [127:0] pts [3];
        logic [255:0] keys [3];
        logic [127:0] exp_q [$];
        logic [127:0] got_q [$];
        int acc_q [$];
        int idx;
        bit pending;
        ksel = k;
        for (int j = 0; j < 3; j++) begin
            pts[j]  = rnd128();
            keys[j] = rnd256();
        end
        idx = 0; pending = 1'b0;
        pt = pts[0]; kin = keys[0]; iv = 1'b1; ordy = 1'b1;
        for (int c = 0; c < 200 && got_q.size() < 3; c++) begin
            if (ov === 1'b1) got_q.push_back(ct);
            if (iv && ir === 1'b1) begin
                acc_q.push_back(cyc + 1);
                exp_q.push_back(aes_model(pt, kin, klen_of(k)));
                idx++;
                pending = 1'b1;
            end
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                if (idx < 3) begin
                    pt = pts[idx]; kin = keys[idx];
                end else begin
                    iv = 1'b0;
                end
            end
        end
        iv = 1'b0; ordy = 1'b0;
        n_cmp++;
        if (got_q.size() != 3 || acc_q.size() != 3) begin
            n_err++;
            $display("FAIL b2b_count k=%0d: got %0d results / %0d acceptances, required 3/3", k, got_q.size(), acc_q.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (got_q[j] !== exp_q[j]) begin
                    n_err++;
                    $display("FAIL b2b_ct k=%0d blk%0d: got %h, required %h", k, j, got_q[j], exp_q[j]);
                end
            end
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (acc_q[j+1] - acc_q[j] != nr_k(k) + 2) begin
                    n_err++;
                    $display("FAIL b2b_spacing k=%0d gap%0d: got %0d, required %0d", k, j, acc_q[j+1] - acc_q[j], nr_k(k) + 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                n_cmp++;
                if (ct !== exp_q[2]) begin
                    n_err++;
                    $display("FAIL b2b_ct_kept k=%0d: got %h, required %h", k, ct, exp_q[2]);
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips(0);
        test_fips(1);
        test_hold();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
